// File: rtl/lzma2_pkg.sv
// lzma2_pkg: shared arbiter state type and default sizing
package lzma2_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2,
    DRAIN    = 2'd3
  } arb_state_t;
  localparam int NUM_REQ_DEF = 4;
  localparam int TIMEOUT_DEF = 63;
endpackage

// File: rtl/lzma2_rr_arbiter.sv
// lzma2_rr_arbiter: combinational round-robin picker starting at ptr
module lzma2_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic               grant_valid,
  output logic [IW-1:0]      grant_idx
);
  // scan from the farthest offset down so the request nearest ptr wins last
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % NUM_REQ]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'((int'(ptr) + i) % NUM_REQ);
      end
    end
  end
endmodule

// File: rtl/lzma2_mem_arbiter.sv
// lzma2_mem_arbiter: round-robin arbiter of requesters onto a single memory manager port
module lzma2_mem_arbiter
  import lzma2_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 256,
  parameter int TIMEOUT = TIMEOUT_DEF,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]        req_we,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_we,
  output logic                      mem_request_valid,
  input  logic                      mem_ready,
  input  logic                      mem_response_valid,
  input  logic [DATA_W-1:0]         mem_read_data,
  output logic                      busy,
  output logic [IW-1:0]             owner,
  output logic [15:0]               timeout_count
);
  arb_state_t    state;
  logic [IW-1:0] rr_ptr;
  logic [15:0]   wcnt;
  logic          gv;
  logic [IW-1:0] gi;

  lzma2_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req         (req_valid),
    .ptr         (rr_ptr),
    .grant_valid (gv),
    .grant_idx   (gi)
  );

  assign busy = state != IDLE;

  // transaction FSM; pulses default low and are raised for exactly one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      rr_ptr            <= '0;
      owner             <= '0;
      wcnt              <= '0;
      timeout_count     <= '0;
      req_ready         <= '0;
      rsp_valid         <= '0;
      rsp_data          <= '0;
      rsp_err           <= 1'b0;
      mem_addr          <= '0;
      mem_wdata         <= '0;
      mem_we            <= 1'b0;
      mem_request_valid <= 1'b0;
    end else begin
      req_ready         <= '0;
      rsp_valid         <= '0;
      rsp_err           <= 1'b0;
      mem_request_valid <= 1'b0;
      case (state)
        IDLE: if (gv && mem_ready) begin
          owner             <= gi;
          mem_addr          <= req_addr[int'(gi)*ADDR_W +: ADDR_W];
          mem_wdata         <= req_wdata[int'(gi)*DATA_W +: DATA_W];
          mem_we            <= req_we[gi];
          req_ready         <= NUM_REQ'(1) << gi;
          mem_request_valid <= 1'b1;
          state             <= ISSUE;
        end
        ISSUE: begin
          rr_ptr <= (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
          wcnt   <= '0;
          state  <= WAIT_RSP;
        end
        WAIT_RSP: begin
          wcnt <= wcnt + 16'd1;
          if (mem_response_valid) begin
            rsp_valid <= NUM_REQ'(1) << owner;
            rsp_data  <= mem_read_data;
            state     <= IDLE;
          end else if (wcnt == 16'(TIMEOUT)) begin
            rsp_valid     <= NUM_REQ'(1) << owner;
            rsp_err       <= 1'b1;
            rsp_data      <= '0;
            timeout_count <= (timeout_count == 16'hFFFF) ? timeout_count : timeout_count + 16'd1;
            state         <= DRAIN;
          end
        end
        DRAIN: state <= mem_ready ? IDLE : DRAIN;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lzma2_mem_arbiter.sv
// tb_lzma2_mem_arbiter: directed table and corner-case sequences for the memory arbiter
module tb_lzma2_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 15;
  localparam int DW = 256;
  localparam int TO = 63;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_we = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            rsp_err;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_we;
  logic            mem_request_valid;
  logic            mem_ready = 1'b0;
  logic            mem_response_valid = 1'b0;
  logic [DW-1:0]   mem_read_data = '0;
  logic            busy;
  logic [1:0]      owner;
  logic [15:0]     timeout_count;

  lzma2_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .req_valid          (req_valid),
    .req_addr           (req_addr),
    .req_wdata          (req_wdata),
    .req_we             (req_we),
    .req_ready          (req_ready),
    .rsp_valid          (rsp_valid),
    .rsp_data           (rsp_data),
    .rsp_err            (rsp_err),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .mem_we             (mem_we),
    .mem_request_valid  (mem_request_valid),
    .mem_ready          (mem_ready),
    .mem_response_valid (mem_response_valid),
    .mem_read_data      (mem_read_data),
    .busy               (busy),
    .owner              (owner),
    .timeout_count      (timeout_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  mask;
    logic        we;
    int          exp_o;
    int          d;
    logic [31:0] rd;
  } vec_t;

  vec_t          tbl [7];
  logic [AW-1:0] a [N] = '{15'h0080, 15'h0100, 15'h2000, 15'h7FF0};
  int            checks = 0;
  int            errors = 0;
  int            early;

  function automatic logic [DW-1:0] wd(input int i);
    return {8{32'(32'hA5A5_0000 + i)}};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input string name, input logic [3:0] mask, input logic we, input int exp_o,
                         input int d, input logic [31:0] rd, input bit keep);
    logic [DW-1:0] rdat;
    int            pre;
    rdat = {8{rd}};
    pre = 0;
    req_valid = mask;
    req_we = {N{we}};
    mem_ready = 1'b1;
    step();
    chk({name, " ready"}, req_ready, 4'b1 << exp_o);
    chk({name, " strobe"}, mem_request_valid, 1);
    chk({name, " owner"}, owner, exp_o);
    chk({name, " addr"}, mem_addr, a[exp_o]);
    chk({name, " wdata"}, mem_wdata, wd(exp_o));
    chk({name, " we"}, mem_we, we);
    if (!keep) req_valid = '0;
    step();
    chk({name, " strobe_end"}, {req_ready, mem_request_valid}, 0);
    repeat (d) begin
      if (rsp_valid != 0) pre++;
      step();
    end
    if (rsp_valid != 0) pre++;
    mem_response_valid = 1'b1;
    mem_read_data = rdat;
    step();
    mem_response_valid = 1'b0;
    chk({name, " early_rsp"}, pre, 0);
    chk({name, " rsp_valid"}, rsp_valid, 4'b1 << exp_o);
    chk({name, " rsp_data"}, rsp_data, rdat);
    chk({name, " rsp_err"}, rsp_err, 0);
    chk({name, " idle"}, busy, 0);
  endtask

  initial begin
    tbl[0] = '{4'b0010, 1'b0, 1, 9, 32'h1111_0001};
    tbl[1] = '{4'b0011, 1'b0, 0, 3, 32'h2222_0002};
    tbl[2] = '{4'b1001, 1'b0, 3, 1, 32'h3333_0003};
    tbl[3] = '{4'b1111, 1'b0, 0, 5, 32'h4444_0004};
    tbl[4] = '{4'b0100, 1'b1, 2, 2, 32'h5555_0005};
    tbl[5] = '{4'b0011, 1'b0, 0, 4, 32'h6666_0006};
    tbl[6] = '{4'b1000, 1'b0, 3, 0, 32'h7777_0007};
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = a[i];
      req_wdata[i*DW +: DW] = wd(i);
    end
    repeat (3) step();
    chk("rst busy", busy, 0);
    chk("rst req_ready", req_ready, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst strobe", mem_request_valid, 0);
    chk("rst owner", owner, 0);
    chk("rst timeout_count", timeout_count, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst rsp_data", rsp_data, 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 7; i++)
      run_txn($sformatf("tbl%0d", i), tbl[i].mask, tbl[i].we, tbl[i].exp_o, tbl[i].d, tbl[i].rd, 1'b0);

    for (int g = 0; g < 5; g++)
      run_txn($sformatf("rr%0d", g), 4'hF, 1'b0, g % 4, 2, 32'h1000 + g, 1'b1);
    req_valid = '0;

    req_valid = 4'b0100;
    step();
    chk("to ready", req_ready, 4'b0100);
    req_valid = '0;
    step();
    early = 0;
    repeat (TO) begin
      if (rsp_valid != 0) early++;
      step();
    end
    if (rsp_valid != 0) early++;
    step();
    chk("to early", early, 0);
    chk("to rsp_valid", rsp_valid, 4'b0100);
    chk("to rsp_err", rsp_err, 1);
    chk("to rsp_data", rsp_data, 0);
    chk("to count", timeout_count, 1);
    chk("to drain busy", busy, 1);
    mem_ready = 1'b0;
    mem_response_valid = 1'b1;
    mem_read_data = {8{32'hDEAD_BEEF}};
    step();
    mem_response_valid = 1'b0;
    chk("drain drop", rsp_valid, 0);
    chk("drain hold", busy, 1);
    chk("drain data", rsp_data, 0);
    mem_ready = 1'b1;
    step();
    chk("drain exit", busy, 0);

    run_txn("expiry", 4'b0001, 1'b0, 0, TO, 32'h0000_C0DE, 1'b0);
    chk("expiry count", timeout_count, 1);

    mem_ready = 1'b0;
    req_valid = 4'b0100;
    early = 0;
    repeat (3) begin
      step();
      if (req_ready != 0 || busy) early++;
    end
    chk("nordy grant", early, 0);
    mem_ready = 1'b1;
    step();
    chk("nordy ready", req_ready, 4'b0100);
    chk("nordy owner", owner, 2);
    req_valid = '0;
    step();
    mem_response_valid = 1'b1;
    step();
    mem_response_valid = 1'b0;
    chk("nordy rsp", rsp_valid, 4'b0100);

    req_valid = 4'b0010;
    step();
    chk("rstw ready", req_ready, 4'b0010);
    req_valid = '0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("rstw busy", busy, 0);
    chk("rstw owner", owner, 0);
    chk("rstw count", timeout_count, 0);
    chk("rstw rsp_data", rsp_data, 0);
    chk("rstw mem_addr", mem_addr, 0);
    chk("rstw pulses", {req_ready, rsp_valid, mem_request_valid, rsp_err}, 0);
    step();
    rst_n = 1'b1;
    mem_response_valid = 1'b1;
    step();
    mem_response_valid = 1'b0;
    chk("rstw stray", rsp_valid, 0);
    chk("rstw idle", busy, 0);
    step();
    chk("rstw stray2", rsp_valid, 0);
    run_txn("post_rst", 4'b1010, 1'b0, 1, 3, 32'h0BAD_F00D, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
